// File: rtl/fir_pkg.sv
// Shared types, default taps and arithmetic helpers for the multi-channel FIR.
// Pure definitions; no latency and no flow control of its own.
// The default coefficient table is padded to COEFF_MAX entries so any tap count up to that fits.
package fir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    localparam int COEFF_MAX = 32;
    typedef int coeff_tab_t [COEFF_MAX];

    // 21-tap symmetric low-pass, Q14; entries beyond the tap count are ignored
    localparam coeff_tab_t COEFF_DEFAULT = '{
        -64, -96, -64, 96, 384, 736, 1088, 1376, 1568, 1696, 1744,
        1696, 1568, 1376, 1088, 736, 384, 96, -64, -96, -64,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0
    };

    function automatic int acc_width(input int bitsize, input int coeffsize, input int length);
        return bitsize + coeffsize + $clog2(length);
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Two-stage multiply/accumulate: product register, then accumulator register.
// Latency 2 cycles from in_vld to acc; no backpressure, one product per cycle.
// in_first restarts the sum, in_last marks the final tap so acc_last flags a finished result.
module fir_mac #(
    parameter int BITSIZE   = 16,
    parameter int COEFFSIZE = 16,
    parameter int ACC_W     = 37
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_vld,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic signed [BITSIZE-1:0]   sample,
    input  logic signed [COEFFSIZE-1:0] coef,
    output logic signed [ACC_W-1:0]     acc,
    output logic                        acc_last
);
    localparam int PROD_W = BITSIZE + COEFFSIZE;

    logic signed [PROD_W-1:0] prod;
    logic                     p_vld;
    logic                     p_first;
    logic                     p_last;
    logic signed [ACC_W-1:0]  prod_ext;

    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod     <= '0;
            p_vld    <= 1'b0;
            p_first  <= 1'b0;
            p_last   <= 1'b0;
            acc      <= '0;
            acc_last <= 1'b0;
        end else begin
            p_vld    <= in_vld;
            p_first  <= in_first;
            p_last   <= in_last;
            if (in_vld)
                prod <= PROD_W'(sample) * PROD_W'(coef);
            acc_last <= p_vld & p_last;
            if (p_vld)
                acc <= p_first ? prod_ext : acc + prod_ext;
        end
    end

endmodule

// File: rtl/fir_mc_seq.sv
// Time-multiplexed CH-channel FIR, one shared MAC; optional coefficient port under FIR_COEFF_LOAD_EN.
// Latency CH*LENGTH+4 cycles from detected START_FLAG edge to DATA_VALID.
// No backpressure: strobes arriving while BUSY are dropped and flagged on OVERRUN.
module fir_mc_seq
    import fir_pkg::*;
#(
    parameter int         BITSIZE    = 16,
    parameter int         COEFFSIZE  = 16,
    parameter int         COEFF_FRAC = 14,
    parameter int         LENGTH     = 21,
    parameter int         CH         = 4,
    parameter coeff_tab_t COEFF_TAB  = COEFF_DEFAULT
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         EN,
    input  logic                         START_FLAG,
    input  logic [CH*BITSIZE-1:0]        DATA_IN,
`ifdef FIR_COEFF_LOAD_EN
    input  logic                         COEFF_WE,
    input  logic [$clog2(LENGTH)-1:0]    COEFF_ADDR,
    input  logic [COEFFSIZE-1:0]         COEFF_DATA,
`endif
    output logic [CH*BITSIZE-1:0]        DATA_OUT,
    output logic                         DATA_VALID,
    output logic                         BUSY,
    output logic                         OVERRUN
);
    localparam int ACC_W = acc_width(BITSIZE, COEFFSIZE, LENGTH);
    localparam int TAP_W = $clog2(LENGTH);
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;

    state_t state_q, state_d;

    logic                         start_q1, start_q2, start_edge;
    logic [TAP_W-1:0]             tap_cnt;
    logic [CH_W-1:0]              ch_cnt;
    logic                         drain_cnt;
    logic                         capture, issue, out_fire;
    logic                         last_tap, last_ch;

    logic signed [BITSIZE-1:0]    dly  [CH][LENGTH];
    logic signed [BITSIZE-1:0]    hold [CH];
    logic signed [COEFFSIZE-1:0]  coef [LENGTH];

    logic signed [BITSIZE-1:0]    mac_sample;
    logic signed [COEFFSIZE-1:0]  mac_coef;
    logic signed [ACC_W-1:0]      acc;
    logic                         acc_last;
    logic signed [63:0]           acc64, rnd64;
    logic signed [BITSIZE-1:0]    result;

    assign start_edge = start_q1 & ~start_q2;
    assign last_tap   = (tap_cnt == TAP_W'(LENGTH - 1));
    assign last_ch    = (ch_cnt == CH_W'(CH - 1));
    assign BUSY       = (state_q != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            start_q1 <= 1'b0;
            start_q2 <= 1'b0;
            state_q  <= IDLE;
        end else begin
            start_q1 <= START_FLAG;
            start_q2 <= start_q1;
            state_q  <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        issue    = 1'b0;
        out_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (EN && start_edge) begin
                    capture = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (!EN)
                    state_d = IDLE;
                else begin
                    issue = 1'b1;
                    if (last_tap && last_ch)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!EN)
                    state_d = IDLE;
                else if (drain_cnt)
                    state_d = OUT;
            end
            OUT: begin
                state_d  = IDLE;
                out_fire = EN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Channel-major walk over the taps; drain_cnt covers the two pipeline stages
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tap_cnt   <= '0;
            ch_cnt    <= '0;
            drain_cnt <= 1'b0;
        end else if (capture) begin
            tap_cnt   <= '0;
            ch_cnt    <= '0;
            drain_cnt <= 1'b0;
        end else if (issue) begin
            if (last_tap) begin
                tap_cnt <= '0;
                ch_cnt  <= ch_cnt + 1'b1;
            end else begin
                tap_cnt <= tap_cnt + 1'b1;
            end
        end else if (state_q == DRAIN) begin
            drain_cnt <= ~drain_cnt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < CH; c++)
                for (int t = 0; t < LENGTH; t++)
                    dly[c][t] <= '0;
        end else if (capture) begin
            for (int c = 0; c < CH; c++) begin
                dly[c][0] <= {~DATA_IN[c*BITSIZE + BITSIZE - 1], DATA_IN[c*BITSIZE +: BITSIZE-1]};
                for (int t = LENGTH - 1; t > 0; t--)
                    dly[c][t] <= dly[c][t-1];
            end
        end
    end

`ifdef FIR_COEFF_LOAD_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < LENGTH; i++)
                coef[i] <= COEFFSIZE'(COEFF_TAB[i]);
        end else if (COEFF_WE && (state_q == IDLE) && (32'(COEFF_ADDR) < LENGTH)) begin
            coef[COEFF_ADDR] <= COEFF_DATA;
        end
    end
`else
    always_comb begin
        for (int i = 0; i < LENGTH; i++)
            coef[i] = COEFFSIZE'(COEFF_TAB[i]);
    end
`endif

    assign mac_sample = dly[ch_cnt][tap_cnt];
    assign mac_coef   = coef[tap_cnt];

    fir_mac #(
        .BITSIZE   (BITSIZE),
        .COEFFSIZE (COEFFSIZE),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk      (CLK),
        .rst      (RST),
        .in_vld   (issue),
        .in_first (tap_cnt == '0),
        .in_last  (last_tap),
        .sample   (mac_sample),
        .coef     (mac_coef),
        .acc      (acc),
        .acc_last (acc_last)
    );

    always_comb begin
        acc64  = {{(64 - ACC_W){acc[ACC_W-1]}}, acc};
        rnd64  = (acc64 + (64'sd1 <<< (COEFF_FRAC - 1))) >>> COEFF_FRAC;
        result = BITSIZE'(sat_signed(rnd64, BITSIZE));
    end

    // Results arrive channel-major, so shifting down leaves channel 0 in hold[0]
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < CH; c++)
                hold[c] <= '0;
            DATA_OUT   <= {CH{1'b1, {(BITSIZE-1){1'b0}}}};
            DATA_VALID <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            if (acc_last) begin
                for (int c = 0; c < CH - 1; c++)
                    hold[c] <= hold[c+1];
                hold[CH-1] <= result;
            end
            DATA_VALID <= out_fire;
            if (out_fire) begin
                for (int c = 0; c < CH; c++)
                    DATA_OUT[c*BITSIZE +: BITSIZE] <= {~hold[c][BITSIZE-1], hold[c][BITSIZE-2:0]};
            end
            if (!EN)
                OVERRUN <= 1'b0;
            else if (start_edge && (state_q != IDLE))
                OVERRUN <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_mc_seq.sv
// Directed bench for fir_mc_seq: 2 channels, 4 taps {4096,8192,-4096,2048}, Q14.
module tb_fir_mc_seq;
    import fir_pkg::*;

    localparam logic [15:0] MID = 16'h8000;
    localparam coeff_tab_t TB_COEFF = '{0: 4096, 1: 8192, 2: -4096, 3: 2048, default: 0};

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start_flag;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_valid;
    logic        busy;
    logic        overrun;
`ifdef FIR_COEFF_LOAD_EN
    logic        coeff_we;
    logic [1:0]  coeff_addr;
    logic [15:0] coeff_data;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [31:0] d;
    int          lat;
    int          nv;

    always #5 clk = ~clk;

    fir_mc_seq #(
        .BITSIZE    (16),
        .COEFFSIZE  (16),
        .COEFF_FRAC (14),
        .LENGTH     (4),
        .CH         (2),
        .COEFF_TAB  (TB_COEFF)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .EN         (en),
        .START_FLAG (start_flag),
        .DATA_IN    (data_in),
`ifdef FIR_COEFF_LOAD_EN
        .COEFF_WE   (coeff_we),
        .COEFF_ADDR (coeff_addr),
        .COEFF_DATA (coeff_data),
`endif
        .DATA_OUT   (data_out),
        .DATA_VALID (data_valid),
        .BUSY       (busy),
        .OVERRUN    (overrun)
    );

    function automatic logic [15:0] ob(input int v);
        return 16'(32768 + v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe one frame and wait (bounded) for DATA_VALID; lat counts edges after the detecting edge
    task automatic run_frame(input logic [31:0] din, output logic [31:0] dout, output int l);
        @(negedge clk); start_flag = 1'b0;
        @(negedge clk); data_in = din; start_flag = 1'b1;
        @(posedge clk);
        l = 0;
        while (l < 40) begin
            @(posedge clk); #1;
            l++;
            if (data_valid) break;
        end
        dout = data_out;
    endtask

    int imp_exp [4] = '{250, 500, -250, 125};
    int ovr_exp [4] = '{500, -250, 125, 0};

    initial begin
        rst = 1'b1; en = 1'b1; start_flag = 1'b0; data_in = {MID, MID};
`ifdef FIR_COEFF_LOAD_EN
        coeff_we = 1'b0; coeff_addr = '0; coeff_data = '0;
`endif
        #1;
        check("reset_data_out", data_out, {MID, MID});
        check("reset_flags", {29'd0, data_valid, busy, overrun}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Impulse on channel 0
        for (int i = 0; i < 4; i++) begin
            run_frame((i == 0) ? {MID, ob(1000)} : {MID, MID}, d, lat);
            check($sformatf("imp_lat%0d", i), lat, 12);
            check($sformatf("imp_out%0d", i), d, {MID, ob(imp_exp[i])});
            if (i == 0) begin
                check("busy_low_at_valid", {31'd0, busy}, 32'd0);
                @(posedge clk); #1;
                check("valid_one_cycle", {31'd0, data_valid}, 32'd0);
            end
        end

        // DC at midpoint
        for (int i = 0; i < 50; i++) begin
            run_frame({MID, MID}, d, lat);
            check($sformatf("dc_lat%0d", i), lat, 12);
            check($sformatf("dc_out%0d", i), d, {MID, MID});
        end

        // Full-scale patterns aligned with coefficient signs drive both rails
        run_frame({16'h0000, 16'hFFFF}, d, lat);
        run_frame({16'hFFFF, 16'h0000}, d, lat);
        run_frame({16'h0000, 16'hFFFF}, d, lat);
        run_frame({16'h0000, 16'hFFFF}, d, lat);
        check("sat_out", d, {16'h0000, 16'hFFFF});
        for (int i = 0; i < 4; i++) run_frame({MID, MID}, d, lat);
        check("sat_flush", d, {MID, MID});

        // Second strobe ten cycles after the first
        @(negedge clk); start_flag = 1'b0;
        @(negedge clk); data_in = {MID, ob(1000)}; start_flag = 1'b1;
        repeat (5) @(negedge clk);
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
        start_flag = 1'b0; data_in = {MID, ob(2000)};
        repeat (5) @(negedge clk);
        start_flag = 1'b1;
        nv = 0;
        repeat (30) begin
            @(negedge clk);
            if (data_valid) begin nv++; d = data_out; end
        end
        check("ovr_valid_count", nv, 1);
        check("ovr_flag_set", {31'd0, overrun}, 32'd1);
        check("ovr_out", d, {MID, ob(250)});
        en = 1'b0;
        @(negedge clk); en = 1'b1;
        check("ovr_flag_cleared", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            run_frame({MID, MID}, d, lat);
            check($sformatf("ovr_follow%0d", i), d, {MID, ob(ovr_exp[i])});
        end

        // Abort in the middle of MAC
        @(negedge clk); start_flag = 1'b0;
        @(negedge clk); data_in = {MID, ob(1000)}; start_flag = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        en = 1'b1;
        nv = 0;
        repeat (25) begin
            @(negedge clk);
            if (data_valid) nv++;
        end
        check("abort_no_valid", nv, 0);
        check("abort_out_held", data_out, {MID, MID});
        run_frame({MID, MID}, d, lat);
        check("abort_next_lat", lat, 12);
        check("abort_next_out", d, {MID, ob(500)});

        // Asynchronous reset mid-frame
        @(negedge clk); start_flag = 1'b0;
        @(negedge clk); data_in = {ob(3000), ob(-3000)}; start_flag = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_data_out", data_out, {MID, MID});
        check("rst_mid_flags", {29'd0, data_valid, busy, overrun}, 32'd0);
        @(negedge clk); rst = 1'b0; start_flag = 1'b0;
        run_frame({MID, MID}, d, lat);
        check("rst_lines_cleared", d, {MID, MID});

`ifdef FIR_COEFF_LOAD_EN
        for (int a = 0; a < 4; a++) begin
            @(negedge clk); coeff_we = 1'b1; coeff_addr = 2'(a); coeff_data = (a == 0) ? 16'd16384 : 16'd0;
        end
        @(negedge clk); coeff_we = 1'b0;
        begin
            int sine [4] = '{0, 2000, 0, -2000};
            for (int i = 0; i < 4; i++) begin
                run_frame({ob(sine[i]), ob(sine[i])}, d, lat);
                check($sformatf("load_out%0d", i), d, {ob(sine[i]), ob(sine[i])});
            end
        end
        @(negedge clk); start_flag = 1'b0;
        @(negedge clk); data_in = {MID, ob(700)}; start_flag = 1'b1;
        repeat (4) @(negedge clk);
        coeff_we = 1'b1; coeff_addr = 2'd0; coeff_data = 16'd0;
        @(negedge clk); coeff_we = 1'b0;
        repeat (20) @(negedge clk);
        run_frame({MID, ob(700)}, d, lat);
        check("load_busy_write_dropped", d, {MID, ob(700)});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
